// File: rtl/final_video_pkg.sv
// final_video_pkg -- shared types and constants for final_video_mixer.
//   trans_mask()   : builds the low-bit transparency mask
//   prio_map_t     : rank -> layer map, sized for the largest legal layer count
//   PAL_COMP_*     : palette component offsets (R/G/B) in units of one palette
package final_video_pkg;

  localparam int MAX_LAYERS = 4;

  // Entry k holds the layer number shown at rank k; rank 0 is topmost.
  typedef logic [MAX_LAYERS-1:0][1:0] prio_map_t;

  localparam logic [1:0] PAL_COMP_R = 2'd0;
  localparam logic [1:0] PAL_COMP_G = 2'd1;
  localparam logic [1:0] PAL_COMP_B = 2'd2;

  function automatic logic [31:0] trans_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic prio_map_t identity_map();
    prio_map_t m;
    for (int k = 0; k < MAX_LAYERS; k++) m[k] = k[1:0];
    return m;
  endfunction

endpackage

// File: rtl/final_video_mixer_palette_ram.sv
// mixer_palette_ram -- one colour component of the palette.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : synchronous read port, data one clk after the address
// A same-clk read and write to one address returns the old contents.
// Contents have no reset.
module mixer_palette_ram #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/final_video_mixer.sv
// final_video_mixer -- priority mixer of NUM_LAYERS pixel layers into a
// palette-based RGB output.
//   clk, VIDEO_RSTn     : clock, async active-low reset
//   CEN, HBL, DISP      : pixel strobe, horizontal blank, display enable
//   layer_pix           : layer codes, layer k at [k*PIX_W +: PIX_W]
//   prio_cfg            : rank k at [2k +: 2] holds a layer number, rank 0 top
//   layer_ena_dbg       : per-layer debug enable (only with LAYER_DBG_EN)
//   ioctl_*             : palette download port
//   R, G, B, pix_valid  : output colour and update pulse
//   prio_err            : sticky, an illegal prio_cfg was rejected
// Pipeline: S1 layer codes -> S2 palette index -> palette RAM -> S3 RGB,
// each stage advancing on CEN.
// Build option: define LAYER_DBG_EN to force disabled layers transparent at S1.
module final_video_mixer
  import final_video_pkg::*;
#(
  parameter int          NUM_LAYERS = 3,
  parameter int          PIX_W      = 8,
  parameter int          TRANS_W    = 4,
  parameter int          COL_W      = 4,
  parameter logic [24:0] PAL_BASE   = 25'h80000
) (
  input  logic                        clk,
  input  logic                        VIDEO_RSTn,
  input  logic                        CEN,
  input  logic                        HBL,
  input  logic                        DISP,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_pix,
  input  logic [NUM_LAYERS*2-1:0]     prio_cfg,
  input  logic [NUM_LAYERS-1:0]       layer_ena_dbg,
  input  logic [24:0]                 ioctl_addr,
  input  logic [7:0]                  ioctl_data,
  input  logic                        ioctl_wr,
  output logic [COL_W-1:0]            R,
  output logic [COL_W-1:0]            G,
  output logic [COL_W-1:0]            B,
  output logic                        pix_valid,
  output logic                        prio_err
);

  localparam int              IDX_W    = 2 + PIX_W;
  localparam int              PAL_SIZE = 1 << IDX_W;
  localparam logic [31:0]     TM32     = trans_mask(TRANS_W);
  localparam logic [PIX_W-1:0] TMASK   = TM32[PIX_W-1:0];
  localparam prio_map_t       IDENT    = identity_map();
  localparam logic [2:0][1:0] PAL_COMP = {PAL_COMP_B, PAL_COMP_G, PAL_COMP_R};

  logic [NUM_LAYERS-1:0][PIX_W-1:0] s1_d, s1_q;
  logic [IDX_W-1:0]                 s2_d, s2_q;
  prio_map_t                        map_d, map_q, cfg_map;
  logic                             cfg_ok, hbl_rise, hbl_q;
  logic                             err_d, err_q, vld_d, vld_q;
  logic [1:0]                       sel_layer;
  logic [PIX_W-1:0]                 sel_code;
  logic [2:0][COL_W-1:0]            pal_rd, rgb_d, rgb_q;
  logic [24:0]                      pal_off;
  logic                             pal_hit;

  // S1: sample layer codes
  always_comb begin
    s1_d = s1_q;
    if (CEN) begin
      s1_d = layer_pix;
`ifdef LAYER_DBG_EN
      for (int k = 0; k < NUM_LAYERS; k++)
        if (!layer_ena_dbg[k]) s1_d[k] = '1;
`endif
    end
  end

  // Priority map: validate prio_cfg, load only on HBL rising edge
  always_comb begin
    cfg_map = IDENT;
    cfg_ok  = 1'b1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cfg_map[i] = prio_cfg[2*i +: 2];
      if (int'(cfg_map[i]) >= NUM_LAYERS) cfg_ok = 1'b0;
      for (int j = 0; j < i; j++)
        if (cfg_map[i] == cfg_map[j]) cfg_ok = 1'b0;
    end
  end

  assign hbl_rise = HBL & ~hbl_q;
  assign map_d    = (hbl_rise && cfg_ok) ? cfg_map : map_q;
  assign err_d    = err_q | (hbl_rise & ~cfg_ok);

  // S2: walk ranks bottom-up so the topmost opaque layer wins; if none is
  // opaque the lowest-ranked layer's code falls through unchanged.
  always_comb begin
    sel_layer = map_q[NUM_LAYERS-1];
    sel_code  = s1_q[map_q[NUM_LAYERS-1]];
    for (int r = NUM_LAYERS - 1; r >= 0; r--) begin
      if ((s1_q[map_q[r]] & TMASK) != TMASK) begin
        sel_layer = map_q[r];
        sel_code  = s1_q[map_q[r]];
      end
    end
    s2_d = CEN ? {sel_layer, sel_code} : s2_q;
  end

  // Palette download decode; the subtraction wraps for addresses below the
  // base, so the explicit >= check keeps those out of the window.
  assign pal_off = ioctl_addr - PAL_BASE;
  assign pal_hit = ioctl_wr && (ioctl_addr >= PAL_BASE) && (pal_off < 25'(3*PAL_SIZE));

  for (genvar c = 0; c < 3; c++) begin : g_pal
    mixer_palette_ram #(.AW(IDX_W), .DW(COL_W)) u_ram (
      .clk   (clk),
      .we    (pal_hit && (pal_off[IDX_W+1:IDX_W] == PAL_COMP[c])),
      .waddr (pal_off[IDX_W-1:0]),
      .wdata (ioctl_data[COL_W-1:0]),
      .raddr (s2_q),
      .rdata (pal_rd[c])
    );
  end

  // S3: output colour, blanked outside the display window
  always_comb begin
    rgb_d = rgb_q;
    vld_d = 1'b0;
    if (CEN) begin
      rgb_d = DISP ? pal_rd : '0;
      vld_d = DISP;
    end
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      s1_q  <= '0;
      s2_q  <= '0;
      rgb_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      map_q <= IDENT;
      hbl_q <= 1'b1;  // HBL already high at release is not a rise
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      rgb_q <= rgb_d;
      vld_q <= vld_d;
      err_q <= err_d;
      map_q <= map_d;
      hbl_q <= HBL;
    end
  end

  assign R         = rgb_q[PAL_COMP_R];
  assign G         = rgb_q[PAL_COMP_G];
  assign B         = rgb_q[PAL_COMP_B];
  assign pix_valid = vld_q;
  assign prio_err  = err_q;

`ifdef LAYER_DBG_EN
  logic unused_bits;
  assign unused_bits = ^{pal_off[24:IDX_W+2], ioctl_data[7:COL_W], map_q};
`else
  logic unused_bits;
  assign unused_bits = ^{pal_off[24:IDX_W+2], ioctl_data[7:COL_W], map_q, layer_ena_dbg};
`endif

endmodule

// File: tb/tb_final_video_mixer.sv
module tb_final_video_mixer;
  localparam logic [24:0] PB = 25'h80000;

  logic        clk = 1'b0;
  logic        VIDEO_RSTn = 1'b0;
  logic        CEN = 1'b0, HBL = 1'b0, DISP = 1'b0;
  logic [23:0] layer_pix = '0;
  logic [5:0]  prio_cfg = 6'b10_01_00;
  logic [2:0]  layer_ena_dbg = '1;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [3:0]  R, G, B;
  logic        pix_valid, prio_err;

  int total = 0;
  int bad = 0;

  final_video_mixer dut (
    .clk(clk), .VIDEO_RSTn(VIDEO_RSTn), .CEN(CEN), .HBL(HBL), .DISP(DISP),
    .layer_pix(layer_pix), .prio_cfg(prio_cfg), .layer_ena_dbg(layer_ena_dbg),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .R(R), .G(G), .B(B), .pix_valid(pix_valid), .prio_err(prio_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pal_wr(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic cen1();
    @(negedge clk); CEN = 1'b1;
    @(negedge clk); CEN = 1'b0;
  endtask

  task automatic cen3();
    cen1(); cen1(); cen1();
  endtask

  task automatic hbl_pulse();
    @(negedge clk); HBL = 1'b1;
    @(negedge clk);
    @(negedge clk); HBL = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_R", R, 0);
    check("rst_G", G, 0);
    check("rst_B", B, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_err", prio_err, 0);
    @(negedge clk); VIDEO_RSTn = 1'b1;

    // palette load
    pal_wr(PB + 25'h000, 8'h00);
    pal_wr(PB + 25'h400, 8'h00);
    pal_wr(PB + 25'h800, 8'h00);
    pal_wr(PB + 25'h012, 8'h05);
    pal_wr(PB + 25'h412, 8'h0A);
    pal_wr(PB + 25'h812, 8'h03);
    pal_wr(PB + 25'h0FF, 8'h07);
    pal_wr(PB + 25'h2FF, 8'h09);
    pal_wr(PB + 25'h245, 8'h0C);
    // out-of-window writes must be dropped
    pal_wr(PB + 25'hC12, 8'h0F);
    pal_wr(PB - 25'h800 + 25'h012, 8'h0F);

    // layers {0x12,0x3F,0x4F}, identity map -> idx 0x012
    DISP = 1'b1;
    layer_pix = 24'h4F3F12;
    cen1(); cen1();
    check("lat_2cen_R", R, 0);
    cen1();
    check("basic_R", R, 5);
    check("basic_G", G, 4'hA);
    check("basic_B", B, 3);
    check("basic_valid", pix_valid, 1);
    @(negedge clk);
    check("valid_pulse_end", pix_valid, 0);

    // all transparent, identity -> lowest rank layer 2 -> idx 0x2FF
    layer_pix = 24'hFFFFFF;
    cen3();
    check("alltr_ident_R", R, 9);
    // map {2,1,0} -> lowest rank is layer 0 -> idx 0x0FF
    prio_cfg = 6'b00_01_10;
    hbl_pulse();
    cen3();
    check("alltr_210_R", R, 7);

    // mid-line prio change takes effect only after HBL rise
    layer_pix = 24'h453F12;
    cen3();
    check("map210_R", R, 4'hC);
    prio_cfg = 6'b10_01_00;
    cen3();
    check("midline_hold_R", R, 4'hC);
    hbl_pulse();
    cen3();
    check("after_hbl_R", R, 5);
    check("legal_err", prio_err, 0);

    // illegal configs rejected, map kept, error sticky
    prio_cfg = 6'b01_01_00;
    hbl_pulse();
    check("dup_err", prio_err, 1);
    prio_cfg = 6'b10_01_10;
    hbl_pulse();
    cen3();
    check("dup_map_kept_R", R, 5);
    prio_cfg = 6'b00_01_11;
    hbl_pulse();
    cen3();
    check("range_map_kept_R", R, 5);
    check("err_sticky", prio_err, 1);

    // DISP=0 blanks output
    DISP = 1'b0;
    cen1();
    check("blank_R", R, 0);
    check("blank_G", G, 0);
    check("blank_B", B, 0);
    check("blank_valid", pix_valid, 0);
    // B[0] written during display time
    pal_wr(PB + 25'h800, 8'h06);
    DISP = 1'b1;
    layer_pix = 24'h453F00;
    cen3();
    check("b0_B", B, 6);
    check("b0_R", R, 0);

    // async reset mid-line
    prio_cfg = 6'b00_01_10;
    hbl_pulse();
    layer_pix = 24'h453F12;
    cen3();
    check("pre_rst_R", R, 4'hC);
    @(negedge clk); #2;
    VIDEO_RSTn = 1'b0;
    #1;
    check("arst_R", R, 0);
    check("arst_G", G, 0);
    check("arst_B", B, 0);
    check("arst_valid", pix_valid, 0);
    check("arst_err", prio_err, 0);
    @(negedge clk); VIDEO_RSTn = 1'b1;
    cen3();
    check("post_rst_R", R, 5);
    check("post_rst_G", G, 4'hA);
    check("post_rst_B", B, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
